// File: rtl/gp_regs_pkg.sv
// -----------------------------------------------------------------------------
// gp_regs_pkg
// Shared definitions for the general-purpose register file:
//   - FunSel encodings (FS_DEC, FS_INC, FS_LOAD, FS_CLR)
//   - next_val(): next-state and wrap/saturation event of one register
// Optional build macro: GP_REG_FILE_SATURATE_EN
//   defined   -> inc at all-ones and dec at zero saturate (event still flagged)
//   undefined -> modular wrap
// -----------------------------------------------------------------------------
package gp_regs_pkg;

  // Widest register next_val() can handle; narrower registers are zero-extended.
  localparam int unsigned GP_MAX_W = 64;

  localparam logic [1:0] FS_DEC  = 2'd0;
  localparam logic [1:0] FS_INC  = 2'd1;
  localparam logic [1:0] FS_LOAD = 2'd2;
  localparam logic [1:0] FS_CLR  = 2'd3;

  // Returns {wrap_evt, next}. 'w' is the true register width; all arithmetic is
  // masked to it so the all-ones / zero boundaries are those of the register.
  function automatic logic [GP_MAX_W:0] next_val(
    input logic [GP_MAX_W-1:0] cur,
    input logic [1:0]          fs,
    input logic [GP_MAX_W-1:0] i,
    input int unsigned         w
  );
    logic [GP_MAX_W-1:0] mask;
    logic [GP_MAX_W-1:0] curm;
    logic [GP_MAX_W-1:0] nxt;
    logic                evt;
    logic                is_max;
    logic                is_zero;

    if (w >= GP_MAX_W) begin
      mask = {GP_MAX_W{1'b1}};
    end else begin
      mask = (64'd1 << w) - 64'd1;
    end
    curm    = cur & mask;
    is_max  = (curm == mask);
    is_zero = (curm == 64'd0);
    evt     = 1'b0;
    nxt     = curm;

    case (fs)
      FS_DEC: begin
        evt = is_zero;
`ifdef GP_REG_FILE_SATURATE_EN
        nxt = is_zero ? curm : (curm - 64'd1);
`else
        nxt = (curm - 64'd1) & mask;
`endif
      end
      FS_INC: begin
        evt = is_max;
`ifdef GP_REG_FILE_SATURATE_EN
        nxt = is_max ? curm : (curm + 64'd1);
`else
        nxt = (curm + 64'd1) & mask;
`endif
      end
      FS_LOAD: begin
        evt = 1'b0;
        nxt = i & mask;
      end
      FS_CLR: begin
        evt = 1'b0;
        nxt = 64'd0;
      end
      default: begin
        evt = 1'b0;
        nxt = curm;
      end
    endcase

    return {evt, nxt};
  endfunction

endpackage

// File: rtl/gp_reg_cell.sv
// -----------------------------------------------------------------------------
// gp_reg_cell
// One main register plus its one-deep shadow copy.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears main+shadow)
//   sel_n_i          active-low enable for the FunSel operation
//   fun_sel_i        operation (see gp_regs_pkg FS_*)
//   data_i           load data
//   save_i           shadow <= pre-edge main
//   restore_i        main <= shadow (overrides the FunSel operation)
//   val_o            current main register value
//   wrap_evt_o       combinational: this edge would wrap/saturate this register
// Honours GP_REG_FILE_SATURATE_EN through gp_regs_pkg::next_val().
// -----------------------------------------------------------------------------
module gp_reg_cell
  import gp_regs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_n_i,
  input  logic [1:0]       fun_sel_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             save_i,
  input  logic             restore_i,
  output logic [WIDTH-1:0] val_o,
  output logic             wrap_evt_o
);

  logic [WIDTH-1:0]    r_q;
  logic [WIDTH-1:0]    r_d;
  logic [WIDTH-1:0]    s_q;
  logic [WIDTH-1:0]    s_d;
  logic [GP_MAX_W-1:0] cur_ext_s;
  logic [GP_MAX_W-1:0] din_ext_s;
  logic [GP_MAX_W:0]   nv_s;
  logic                evt_s;

  // Next-state selection: restore beats the FunSel op; save always snapshots
  // the pre-edge main value, so save+restore forms an atomic swap.
  always_comb begin
    cur_ext_s             = '0;
    cur_ext_s[WIDTH-1:0]  = r_q;
    din_ext_s             = '0;
    din_ext_s[WIDTH-1:0]  = data_i;
    nv_s                  = next_val(cur_ext_s, fun_sel_i, din_ext_s, WIDTH);
    r_d                   = r_q;
    s_d                   = s_q;
    evt_s                 = 1'b0;

    if (restore_i) begin
      r_d   = s_q;
      evt_s = 1'b0;
    end else if (!sel_n_i) begin
      r_d   = nv_s[WIDTH-1:0];
      evt_s = nv_s[GP_MAX_W];
    end else begin
      r_d   = r_q;
      evt_s = 1'b0;
    end

    if (save_i) begin
      s_d = r_q;
    end else begin
      s_d = s_q;
    end
  end

  // Main and shadow storage with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q <= '0;
      s_q <= '0;
    end else begin
      r_q <= r_d;
      s_q <= s_d;
    end
  end

  assign val_o      = r_q;
  assign wrap_evt_o = evt_s;

endmodule

// File: rtl/gp_reg_file.sv
// -----------------------------------------------------------------------------
// gp_reg_file
// NREGS x WIDTH general-purpose register file with inc/dec/load/clear,
// a one-deep shadow bank (save / restore / swap), two combinational read
// ports, a combinational zero vector and a registered one-cycle Wrap pulse.
// Ports:
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   FunSel            0=dec 1=inc 2=load 3=clear
//   RegSel            active-low per-register enable
//   I                 load data
//   Save, Restore     shadow snapshot / shadow recall (both = swap)
//   OutASel, OutBSel  read indices; out-of-range indices read as 0
//   OutA, OutB        R[OutASel], R[OutBSel] (no write-through)
//   ZeroVec           bit k = (R[k] == 0)
//   Wrap              registered wrap/saturation pulse
// Optional build macro: GP_REG_FILE_SATURATE_EN (saturating inc/dec).
// -----------------------------------------------------------------------------
module gp_reg_file
  import gp_regs_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 4,
  localparam int unsigned SEL_W = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       FunSel,
  input  logic [NREGS-1:0] RegSel,
  input  logic [WIDTH-1:0] I,
  input  logic             Save,
  input  logic             Restore,
  input  logic [SEL_W-1:0] OutASel,
  input  logic [SEL_W-1:0] OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [NREGS-1:0] ZeroVec,
  output logic             Wrap
);

  logic [WIDTH-1:0] vals_s [NREGS];
  logic [NREGS-1:0] evt_s;
  logic             wrap_d;
  logic             wrap_q;

  for (genvar k = 0; k < NREGS; k++) begin : g_cell
    gp_reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk_i      (CLK),
      .rst_i      (RST),
      .sel_n_i    (RegSel[k]),
      .fun_sel_i  (FunSel),
      .data_i     (I),
      .save_i     (Save),
      .restore_i  (Restore),
      .val_o      (vals_s[k]),
      .wrap_evt_o (evt_s[k])
    );
  end

  // Cells already suppress their event during Restore, so a plain OR suffices.
  always_comb begin
    wrap_d = |evt_s;
  end

  // Wrap pulse register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign Wrap = wrap_q;

  // Read muxes and zero vector; an index with no matching register reads 0.
  always_comb begin
    OutA    = '0;
    OutB    = '0;
    ZeroVec = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (OutASel == SEL_W'(k)) begin
        OutA = vals_s[k];
      end else begin
        OutA = OutA;
      end
      if (OutBSel == SEL_W'(k)) begin
        OutB = vals_s[k];
      end else begin
        OutB = OutB;
      end
      ZeroVec[k] = (vals_s[k] == '0);
    end
  end

endmodule

// File: tb/tb_gp_reg_file.sv
// Self-checking bench for gp_reg_file (default WIDTH=8, NREGS=4).
module tb_gp_reg_file;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [1:0]       FunSel = 2'd0;
  logic [NREGS-1:0] RegSel = 4'hF;
  logic [WIDTH-1:0] I = 8'h00;
  logic             Save = 1'b0;
  logic             Restore = 1'b0;
  logic [1:0]       OutASel = 2'd0;
  logic [1:0]       OutBSel = 2'd0;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic [NREGS-1:0] ZeroVec;
  logic             Wrap;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: main registers, shadow bank, expected Wrap.
  int m_r [NREGS];
  int m_s [NREGS];
  bit m_wrap = 1'b0;

  gp_reg_file dut (
    .CLK     (CLK),
    .RST     (RST),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .I       (I),
    .Save    (Save),
    .Restore (Restore),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB),
    .ZeroVec (ZeroVec),
    .Wrap    (Wrap)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: evaluates the register-file rules at every rising edge.
  always @(posedge CLK) begin
    int old_r [NREGS];
    bit w;
    for (int k = 0; k < NREGS; k++) old_r[k] = m_r[k];
    if (RST) begin
      for (int k = 0; k < NREGS; k++) begin
        m_r[k] = 0;
        m_s[k] = 0;
      end
      m_wrap = 1'b0;
    end else begin
      w = 1'b0;
      if (Restore) begin
        for (int k = 0; k < NREGS; k++) m_r[k] = m_s[k];
      end else begin
        for (int k = 0; k < NREGS; k++) begin
          if (!RegSel[k]) begin
            case (FunSel)
              2'd0: begin
                if (old_r[k] == 0) begin
                  w = 1'b1;
`ifdef GP_REG_FILE_SATURATE_EN
                  m_r[k] = 0;
`else
                  m_r[k] = MAXV;
`endif
                end else m_r[k] = old_r[k] - 1;
              end
              2'd1: begin
                if (old_r[k] == MAXV) begin
                  w = 1'b1;
`ifdef GP_REG_FILE_SATURATE_EN
                  m_r[k] = MAXV;
`else
                  m_r[k] = 0;
`endif
                end else m_r[k] = old_r[k] + 1;
              end
              2'd2: m_r[k] = int'(I);
              default: m_r[k] = 0;
            endcase
          end
        end
      end
      if (Save) begin
        for (int k = 0; k < NREGS; k++) m_s[k] = old_r[k];
      end
      m_wrap = w;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    logic [NREGS-1:0] zv;
    for (int k = 0; k < NREGS; k++) zv[k] = (m_r[k] == 0);
    check("OutA", 32'(OutA), 32'(m_r[OutASel]));
    check("OutB", 32'(OutB), 32'(m_r[OutBSel]));
    check("ZeroVec", 32'(ZeroVec), 32'(zv));
    check("Wrap", 32'(Wrap), 32'(m_wrap));
  end

  // Drive one cycle of inputs; returns just after the following falling edge.
  task automatic apply(input logic [1:0] fs, input logic [3:0] rs, input logic [7:0] d,
                       input logic sv, input logic rt, input logic rst);
    FunSel = fs; RegSel = rs; I = d; Save = sv; Restore = rt; RST = rst;
    @(negedge CLK);
    #1;
  endtask

  task automatic idle();
    apply(2'd0, 4'hF, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    OutASel = a; OutBSel = b;
    #1;
  endtask

  initial begin
    // 1. Reset dominates an enabled increment.
    apply(2'd1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(2'd1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    rd(2'd0, 2'd3);
    check("rst_outa", 32'(OutA), 32'h0);
    check("rst_outb", 32'(OutB), 32'h0);
    check("rst_zerovec", 32'(ZeroVec), 32'hF);
    check("rst_wrap", 32'(Wrap), 32'h0);

    // 2. Parallel load of R0 and R2.
    apply(2'd2, 4'b1010, 8'hA5, 1'b0, 1'b0, 1'b0);
    rd(2'd0, 2'd2);
    check("load_r0", 32'(OutA), 32'hA5);
    check("load_r2", 32'(OutB), 32'hA5);
    rd(2'd1, 2'd3);
    check("load_r1", 32'(OutA), 32'h00);
    check("load_zerovec", 32'(ZeroVec), 32'hA);

    // 3. Wrap on R3.
    apply(2'd2, 4'b0111, 8'hFF, 1'b0, 1'b0, 1'b0);
    apply(2'd1, 4'b0111, 8'h00, 1'b0, 1'b0, 1'b0);
    rd(2'd3, 2'd0);
`ifdef GP_REG_FILE_SATURATE_EN
    check("inc_r3", 32'(OutA), 32'hFF);
`else
    check("inc_r3", 32'(OutA), 32'h00);
`endif
    check("inc_wrap", 32'(Wrap), 32'h1);
    idle();
    check("wrap_pulse_end", 32'(Wrap), 32'h0);
    apply(2'd0, 4'b0111, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef GP_REG_FILE_SATURATE_EN
    check("dec_r3", 32'(OutA), 32'hFE);
    check("dec_wrap", 32'(Wrap), 32'h0);
`else
    check("dec_r3", 32'(OutA), 32'hFF);
    check("dec_wrap", 32'(Wrap), 32'h1);
`endif

    // 4. Save with a concurrent clear, then restore.
    apply(2'd2, 4'b1110, 8'h11, 1'b0, 1'b0, 1'b0);
    apply(2'd2, 4'b1101, 8'h22, 1'b0, 1'b0, 1'b0);
    apply(2'd3, 4'b1110, 8'h00, 1'b1, 1'b0, 1'b0);
    rd(2'd0, 2'd1);
    check("save_clr_r0", 32'(OutA), 32'h00);
    apply(2'd0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("restore_r0", 32'(OutA), 32'h11);
    check("restore_r1", 32'(OutB), 32'h22);

    // 5. Swap.
    apply(2'd2, 4'b1110, 8'h09, 1'b0, 1'b0, 1'b0);
    apply(2'd0, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0);
    apply(2'd2, 4'b1110, 8'h05, 1'b0, 1'b0, 1'b0);
    apply(2'd0, 4'hF, 8'h00, 1'b1, 1'b1, 1'b0);
    check("swap_r0", 32'(OutA), 32'h09);
    apply(2'd0, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0);
    check("swap_back_r0", 32'(OutA), 32'h05);

    // 6. Priority: reset over restore/load, then restore over a wrapping inc.
    apply(2'd2, 4'h0, 8'h7F, 1'b0, 1'b1, 1'b1);
    check("prio_rst_zv", 32'(ZeroVec), 32'hF);
    apply(2'd0, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0);
    check("prio_shadow_zv", 32'(ZeroVec), 32'hF);
    apply(2'd2, 4'b1110, 8'hFF, 1'b1, 1'b0, 1'b0);
    apply(2'd2, 4'b1110, 8'hFF, 1'b1, 1'b0, 1'b0);
    apply(2'd1, 4'b1110, 8'h00, 1'b0, 1'b1, 1'b0);
    rd(2'd0, 2'd0);
    check("restore_inc_r0", 32'(OutA), 32'hFF);
    check("restore_inc_wrap", 32'(Wrap), 32'h0);

    // Randomized traffic, biased toward the wrap boundaries.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] d;
      case ($urandom_range(3, 0))
        0: d = 8'hFF;
        1: d = 8'h00;
        2: d = 8'h01;
        default: d = 8'($urandom);
      endcase
      OutASel = 2'($urandom);
      OutBSel = 2'($urandom);
      apply(2'($urandom), 4'($urandom), d,
            ($urandom_range(7, 0) == 0), ($urandom_range(9, 0) == 0),
            ($urandom_range(63, 0) == 0));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gp_reg_file.md
Name: gp_reg_file

Overview:
Parametrised general-purpose register file, successor to the fixed 4 x 8-bit register bank. Provides NREGS registers of WIDTH bits, each with the shared inc/dec/load/clear function set, plus two independent combinational read ports. Adds synchronous reset, per-cycle wrap detection, and a one-deep shadow bank for interrupt context save/restore/swap. Sits between MuxA (write data) and ALU/MuxC (read ports) in the datapath.

Parameters:
WIDTH, 8, bit width of every register, I, OutA, OutB.
NREGS, 4, number of registers; legal range 2..16.
SEL_W, $clog2(NREGS), localparam only (not overridable); width of the read selects.

Ports:
CLK  in  1  rising-edge clock.
RST  in  1  synchronous, active-high reset.
FunSel  in  2  0=decrement, 1=increment, 2=load I, 3=clear.
RegSel  in  NREGS  active-low per-register enable; bit k low means register k executes FunSel.
I  in  WIDTH  load data.
Save  in  1  copy all main registers into the shadow bank.
Restore  in  1  copy the shadow bank into all main registers.
OutASel  in  SEL_W  read port A index.
OutBSel  in  SEL_W  read port B index.
OutA  out  WIDTH  R[OutASel], combinational.
OutB  out  WIDTH  R[OutBSel], combinational.
ZeroVec  out  NREGS  bit k = (R[k] == 0), combinational.
Wrap  out  1  registered; 1 for one cycle after any wrapping inc/dec.

Behaviour:
- Reset: all R[k]=0, all shadow S[k]=0, Wrap=0. As a result OutA=OutB=0 and ZeroVec=all ones. RST dominates Save, Restore and FunSel.
- Per-edge priority is RST > Restore > FunSel.
- Restore=1: R[k] <= S[k] for all k. RegSel and FunSel are ignored that cycle. Wrap <= 0.
- Otherwise, for each k with RegSel[k]=0:
  - dec: R[k] <= R[k]-1, mod 2^WIDTH.
  - inc: R[k] <= R[k]+1, mod 2^WIDTH.
  - load: R[k] <= I.
  - clear: R[k] <= 0.
  - Registers with RegSel[k]=1 hold. Multiple enabled registers update in parallel from their own pre-edge values.
- Save=1: S[k] <= pre-edge R[k] for all k. Save operates independently of FunSel.
  - Save with FunSel activity: shadow receives old values; main receives new values.
  - Save=1 with Restore=1: atomic swap. R <= S and S <= old R.
- Wrap <= 1 iff (not Restore) and at least one enabled register does either of:
  - FunSel=inc with pre-edge value all-ones;
  - FunSel=dec with pre-edge value 0.
  Otherwise Wrap <= 0. Wrap is a single-cycle pulse.
- Read ports:
  - Pure muxes of the current register state, with no write-through. A write is visible on OutA/OutB the cycle after the edge.
  - Select values >= NREGS (only possible when NREGS is not a power of two) read as 0.
  - A and B may select the same register.
- Latency: write-to-read 1 cycle; Wrap 1 cycle after the causing edge; ZeroVec follows R combinationally.
- RegSel all ones with Save=Restore=0 is a full hold. Wrap <= 0.

Optional Feature:
Macro GP_REG_FILE_SATURATE_EN.
- Defined:
  - inc at all-ones holds all-ones; dec at 0 holds 0.
  - Wrap reports these saturation events, with the same timing as in the undefined case.
- Undefined: modular wrap as described above.
- Load, clear, reset, save and restore are identical in both builds.

Decomposition:
- Shared package gp_regs_pkg holds:
  - FunSel encoding constants FS_DEC=2'd0, FS_INC=2'd1, FS_LOAD=2'd2, FS_CLR=2'd3;
  - a function next_val(cur, fs, i) returning {wrap_evt, next}, honouring GP_REG_FILE_SATURATE_EN.
- One natural sub-module: gp_reg_cell. It holds one main and one shadow register and computes its own wrap event, plus its RST/Restore/Save/enable logic. It is instantiated NREGS times via generate; the top level ORs the wrap events and builds the read muxes.

Test Plan:
1. Reset value: assert RST with FunSel=1 and RegSel=0. Expect all R=0, OutA=OutB=0, ZeroVec=4'b1111, Wrap=0.
2. Parallel load: FunSel=2, I=8'hA5, RegSel=4'b1010 (R0 and R2 enabled). Next cycle expect OutASel=0 gives A5, OutBSel=2 gives A5, OutASel=1 gives 0, and ZeroVec=4'b1010.
3. Wrap: load R3=8'hFF, then FunSel=1 with RegSel=4'b0111. Expect R3=00 and a Wrap pulse of exactly one cycle. Then FunSel=0 on R3 gives R3=FF and Wrap=1. With GP_REG_FILE_SATURATE_EN defined, expect R3 to stay FF on inc and Wrap=1.
4. Save and modify: with R0=11, R1=22, assert Save together with FunSel=3 and RegSel=4'b1110. Expect R0=00 and S0=11. Then Restore=1 gives R0=11 and R1=22.
5. Swap: set R0=05 and S0=09, then assert Save and Restore in the same cycle. Expect R0=09 and S0=05. Assert Restore again: expect R0=05.
6. Priority: assert RST together with Restore and FunSel=2 and I=7F. Expect all registers 0 and the shadow 0 (verified by a subsequent Restore giving R=0). Also check Restore with FunSel=1 on a wrapping register gives Wrap=0.
